// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-entry {L,R} holding buffer feeding a 32-slot frame,
// MSB first with the standard one-BCK delay after each word-select change.
module i2s_audio_tx #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  logic [7:0]  r_div_cnt;
  logic        r_bck;
  logic [4:0]  r_k;
  logic [31:0] r_word;
  logic [31:0] r_buf;
  logic        r_full;
  logic        r_ready_en;
  logic        r_lrck;
  logic        r_data;
  logic        r_frame_start;
  logic        r_underrun;

  logic        w_tick;
  logic        w_fall;
  logic [4:0]  w_k_next;
  logic        w_load;
  logic        w_accept;
  logic [4:0]  w_idx;

  assign w_tick   = (r_div_cnt == DIV_M1);
  assign w_fall   = w_tick && r_bck;
  assign w_k_next = r_k + 5'd1;
  assign w_load   = w_fall && (w_k_next == 5'd0);
  // Handshake: a sample transfers on any rising clk where sample_valid and
  // sample_ready are both high; ready never depends on valid.
  assign w_accept = sample_valid && sample_ready;
  // Slot k carries W[(32-k) mod 32]; slot 0 reads the word before the load.
  assign w_idx    = 5'd0 - w_k_next;

  assign sample_ready = r_ready_en && !r_full;
  assign i2s_bck      = r_bck;
  assign i2s_lrck     = r_lrck;
  assign i2s_data     = r_data;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div_cnt     <= 8'd0;
      r_bck         <= 1'b0;
      r_k           <= 5'd31;
      r_word        <= 32'd0;
      r_buf         <= 32'd0;
      r_full        <= 1'b0;
      r_ready_en    <= 1'b0;
      r_lrck        <= 1'b0;
      r_data        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_ready_en    <= 1'b1;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      if (w_tick) begin
        r_div_cnt <= 8'd0;
        r_bck     <= !r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end

      if (w_fall) begin
        r_k    <= w_k_next;
        r_lrck <= w_k_next[4];
        r_data <= r_word[w_idx];
      end

      // A load that finds the buffer empty repeats the previous word.
      if (w_load) begin
        r_frame_start <= 1'b1;
        if (r_full) begin
          r_word <= r_buf;
          r_full <= 1'b0;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      // Accept only happens with r_full=0, so it never races the clear above.
      if (w_accept) begin
        r_buf  <= {left_in, right_in};
        r_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 Parameter DIV, default 4, clk cycles per BCK half-period (legal range 1..255).
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 left_in  in  16  left sample, two's complement.
REQ-005 right_in  in  16  right sample, two's complement.
REQ-006 sample_valid  in  1  producer offers left_in/right_in this cycle.
REQ-007 sample_ready  out  1  holding buffer empty; sample accepted when valid and ready.
REQ-008 i2s_bck  out  1  serial bit clock.
REQ-009 i2s_lrck  out  1  word select; 0 = left, 1 = right.
REQ-010 i2s_data  out  1  serial data, MSB first, one-BCK I2S delay.
REQ-011 frame_start  out  1  one-clk pulse at frame boundary.
REQ-012 underrun  out  1  one-clk pulse at a frame boundary that finds the buffer empty.

Function
REQ-013 Divider div_cnt counts 0..DIV-1; at DIV-1 it wraps to 0 and i2s_bck toggles. BCK period is 2*DIV clk.
REQ-014 A falling edge is the cycle in which i2s_bck is set 1->0. Slot counter k (0..31) advances by one, mod 32, only on falling edges.
REQ-015 Frame is 32 slots, period 64*DIV clk. i2s_lrck = 0 for k 0..15 and 1 for k 16..31, updated only on falling edges.
REQ-016 Frame word W = {L[15:0], R[15:0]}. At slot k, i2s_data = W[(32-k) mod 32]. Slot 0 carries bit 0 of the previous frame's word; slot 1 carries L MSB; slot 17 carries R MSB.
REQ-017 Holding buffer is one {L,R} entry with a full flag. sample_ready = !full. Accept when sample_valid && sample_ready: the buffer captures left_in/right_in, and full is set next cycle.
REQ-018 Load occurs in the falling-edge cycle where k becomes 0. On load:
- if full: the shift word takes the buffer and full clears;
- else: the shift word is retained (previous sample repeats) and underrun pulses.
REQ-019 frame_start pulses exactly in the load cycle; underrun is never asserted outside it.
REQ-020 Accept and load in the same cycle: this is only possible with full=0. The load sees the buffer as empty (underrun=1, word repeats); the accepted sample sets full=1 and waits for the next frame.
REQ-021 While sample_ready=0, left_in/right_in/sample_valid are ignored; the buffer content is unchanged.
REQ-022 Pipeline latency: an accepted sample's L MSB appears on i2s_data at slot 1 of the first frame whose load follows acceptance.

Reset
REQ-023 While reset_n=0, the next-cycle state is:
- i2s_bck=0, i2s_lrck=0, i2s_data=0;
- frame_start=0, underrun=0, sample_ready=0;
- div_cnt=0, k=31, shift word=0, full=0.
REQ-024 sample_ready is 1 in the first cycle after reset_n returns high.
REQ-025 The first falling edge occurs 2*DIV clk after reset release and is a frame boundary (k=0).
REQ-026 Reset asserted mid-frame discards the buffered and in-flight samples; no partial frame resumes.

Verification
REQ-027 DIV=2. Release reset, offer L=0x8001 and R=0x7FFE with valid held.
- sample_ready falls 1 clk after acceptance.
- frame_start occurs 4 clk after release.
- Next frame data: slot1=1, slots 2..15=0, slot16=1, slot17=0, slots 18..31=1, next slot0=0.
REQ-028 Underrun: after one accepted sample, hold valid=0. Each following frame_start coincides with underrun=1, and i2s_data repeats the identical 32-bit pattern.
REQ-029 Backpressure: with the buffer full, change left_in to 0x1234 and right_in to 0x5678 while ready=0. Check that ready stays 0 until the load, the old word is serialised, and 0x1234/0x5678 is accepted only after ready returns to 1.
REQ-030 Simultaneous accept and load: assert valid first in the load cycle with full=0.
- underrun=1 and the word repeats this frame.
- The new sample is serialised in the following frame.
REQ-031 Reset mid-frame: reset_n=0 for 1 clk at slot 10. Next cycle all outputs equal their REQ-023 values. The first frame_start follows 2*DIV clk after release, with underrun=1 and data all zero.
REQ-032 Timing check (DIV=1 and DIV=4):
- i2s_lrck changes only in falling-edge cycles;
- BCK high and low times are exactly DIV clk each;
- frame_start spacing is exactly 64*DIV clk.
